hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 16-bit five-stage core. It sits on the control side of the ID/EX pipeline register and drives that register's write-enable and clear inputs, plus those of the PC, IF/ID and EX/MEM registers. It detects load-use hazards against the instruction held in ID/EX, flushes wrong-path instructions on a taken branch, and freezes the whole pipeline while data memory is not ready. A watchdog flags memory requests that never complete.

---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and memory-freeze control for the
// five-stage pipeline, with saturating event counters and a memory watchdog.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL     = 1,
  parameter int unsigned BRANCH_PENALTY = 1,
  parameter int unsigned MEM_TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] IDRs1,
  input  logic [15:0] IDRs2,
  input  logic        IDUsesRs2,
  input  logic [15:0] EXRd,
  input  logic        EXMemRead,
  input  logic        EXRegWrite,
  input  logic        BranchTaken,
  input  logic        MemReq,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXWrite,
  output logic        IDEXFlush,
  output logic        EXMEMWrite,
  output logic [1:0]  State,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount,
  output logic        MemError
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] LOADSTALL = 2'd1;
  localparam logic [1:0] FLUSH     = 2'd2;

  localparam logic [2:0] LS_PEN  = 3'(LOAD_STALL - 1);
  localparam logic [2:0] BR_PEN  = 3'(BRANCH_PENALTY - 1);
  localparam logic [8:0] TIMEOUT = 9'(MEM_TIMEOUT);

  logic [1:0]  state;
  logic [2:0]  pen;
  logic [7:0]  wait_cnt;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        mem_err;

  logic freeze;
  logic load_use;
  logic branch_resp;
  logic load_resp;

  // Hazard decode; a taken branch masks the load-use response because the
  // instruction in ID is on the wrong path.
  always_comb begin
    freeze      = MemReq & ~MemReady;
    load_use    = EXMemRead & EXRegWrite & (EXRd != '0) &
                  ((EXRd == IDRs1) | (IDUsesRs2 & (EXRd == IDRs2)));
    branch_resp = ((state == RUN) & BranchTaken) | (state == FLUSH);
    load_resp   = ~branch_resp & (((state == RUN) & load_use) | (state == LOADSTALL));
  end

  // Pipeline register enables and clears, in priority order.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXWrite  = 1'b1;
    IDEXFlush  = 1'b0;
    EXMEMWrite = 1'b1;
    if (Reset) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXWrite  = 1'b0;
      IDEXFlush  = 1'b1;
      EXMEMWrite = 1'b0;
    end else if (freeze) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
    end else if (branch_resp) begin
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
    end else if (load_resp) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXFlush  = 1'b1;
    end
  end

  // FSM, penalty counter, statistics and watchdog; everything but the
  // watchdog holds while memory freezes the pipeline.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= RUN;
      pen       <= '0;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      mem_err   <= 1'b0;
    end else if (freeze) begin
      if (wait_cnt != '1)
        wait_cnt <= wait_cnt + 8'd1;
      if (({1'b0, wait_cnt} + 9'd1) == TIMEOUT)
        mem_err <= 1'b1;
    end else begin
      wait_cnt <= '0;
      if (load_resp && stall_cnt != '1)
        stall_cnt <= stall_cnt + 16'd1;
      case (state)
        RUN: begin
          if (BranchTaken) begin
            if (flush_cnt != '1)
              flush_cnt <= flush_cnt + 16'd1;
            if (BRANCH_PENALTY > 1) begin
              state <= FLUSH;
              pen   <= BR_PEN;
            end
          end else if (load_use) begin
            if (LOAD_STALL > 1) begin
              state <= LOADSTALL;
              pen   <= LS_PEN;
            end
          end
        end
        LOADSTALL, FLUSH: begin
          pen <= pen - 3'd1;
          if (pen == 3'd1)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign State      = state;
  assign StallCount = stall_cnt;
  assign FlushCount = flush_cnt;
  assign MemError   = mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl using two instances with
// different stall/penalty/timeout parameters driven by shared inputs.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] IDRs1, IDRs2, EXRd;
  logic        IDUsesRs2, EXMemRead, EXRegWrite, BranchTaken, MemReq, MemReady;

  logic        pcw_a, ifw_a, iff_a, idw_a, idf_a, exw_a, err_a;
  logic        pcw_b, ifw_b, iff_b, idw_b, idf_b, exw_b, err_b;
  logic [1:0]  st_a, st_b;
  logic [15:0] sc_a, sc_b, fc_a, fc_b;
  logic [5:0]  ctl_a, ctl_b;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite}
  localparam logic [5:0] RST  = 6'b001010;
  localparam logic [5:0] FRZ  = 6'b000000;
  localparam logic [5:0] BR   = 6'b111111;
  localparam logic [5:0] LD   = 6'b000111;
  localparam logic [5:0] NORM = 6'b110101;

  assign ctl_a = {pcw_a, ifw_a, iff_a, idw_a, idf_a, exw_a};
  assign ctl_b = {pcw_b, ifw_b, iff_b, idw_b, idf_b, exw_b};

  always #5 CLK = ~CLK;

  hazard_ctrl #(.LOAD_STALL(1), .BRANCH_PENALTY(1), .MEM_TIMEOUT(255)) dut_a (
    .CLK(CLK), .Reset(Reset), .IDRs1(IDRs1), .IDRs2(IDRs2), .IDUsesRs2(IDUsesRs2),
    .EXRd(EXRd), .EXMemRead(EXMemRead), .EXRegWrite(EXRegWrite),
    .BranchTaken(BranchTaken), .MemReq(MemReq), .MemReady(MemReady),
    .PCWrite(pcw_a), .IFIDWrite(ifw_a), .IFIDFlush(iff_a), .IDEXWrite(idw_a),
    .IDEXFlush(idf_a), .EXMEMWrite(exw_a), .State(st_a), .StallCount(sc_a),
    .FlushCount(fc_a), .MemError(err_a)
  );

  hazard_ctrl #(.LOAD_STALL(3), .BRANCH_PENALTY(2), .MEM_TIMEOUT(4)) dut_b (
    .CLK(CLK), .Reset(Reset), .IDRs1(IDRs1), .IDRs2(IDRs2), .IDUsesRs2(IDUsesRs2),
    .EXRd(EXRd), .EXMemRead(EXMemRead), .EXRegWrite(EXRegWrite),
    .BranchTaken(BranchTaken), .MemReq(MemReq), .MemReady(MemReady),
    .PCWrite(pcw_b), .IFIDWrite(ifw_b), .IFIDFlush(iff_b), .IDEXWrite(idw_b),
    .IDEXFlush(idf_b), .EXMEMWrite(exw_b), .State(st_b), .StallCount(sc_b),
    .FlushCount(fc_b), .MemError(err_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic hazard(input logic [15:0] rd);
    EXMemRead  = 1'b1;
    EXRegWrite = 1'b1;
    EXRd       = rd;
    IDRs1      = rd;
  endtask

  task automatic no_hazard;
    EXMemRead  = 1'b0;
    EXRegWrite = 1'b0;
    EXRd       = 16'd0;
    IDRs1      = 16'd1;
    IDRs2      = 16'd2;
    IDUsesRs2  = 1'b0;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    cyc;
    cyc;
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    no_hazard;
    BranchTaken = 1'b0;
    MemReq      = 1'b0;
    MemReady    = 1'b0;
    Reset       = 1'b1;

    // Reset behaviour
    #1;
    chk("rst_ctl_a", 16'(ctl_a), 16'(RST));
    chk("rst_ctl_b", 16'(ctl_b), 16'(RST));
    cyc;
    cyc;
    chk("rst_state_a", 16'(st_a), 16'd0);
    chk("rst_stall_a", sc_a, 16'd0);
    chk("rst_flush_a", fc_a, 16'd0);
    chk("rst_err_a", 16'(err_a), 16'd0);
    Reset = 1'b0;
    #1;
    chk("run_ctl_a", 16'(ctl_a), 16'(NORM));
    chk("run_ctl_b", 16'(ctl_b), 16'(NORM));
    chk("run_state_b", 16'(st_b), 16'd0);

    // Single-bubble load-use on A
    hazard(16'd5);
    #1;
    chk("ls1_bubble_a", 16'(ctl_a), 16'(LD));
    chk("ls1_state_a", 16'(st_a), 16'd0);
    cyc;
    no_hazard;
    #1;
    chk("ls1_after_a", 16'(ctl_a), 16'(NORM));
    chk("ls1_stall_a", sc_a, 16'd1);
    chk("ls1_state_after_a", 16'(st_a), 16'd0);

    // B is mid-stall here; reset must return it to RUN
    chk("midstall_state_b", 16'(st_b), 16'd1);
    Reset = 1'b1;
    #1;
    chk("midstall_rst_ctl_b", 16'(ctl_b), 16'(RST));
    cyc;
    chk("midstall_rst_state_b", 16'(st_b), 16'd0);
    cyc;
    Reset = 1'b0;
    #1;

    // EXRd == 0 never stalls
    hazard(16'd0);
    #1;
    chk("rd0_ctl_a", 16'(ctl_a), 16'(NORM));
    cyc;
    chk("rd0_stall_a", sc_a, 16'd0);

    // Rs2 match gated by IDUsesRs2 and EXRegWrite
    EXRd  = 16'd7;
    IDRs1 = 16'd1;
    IDRs2 = 16'd7;
    IDUsesRs2 = 1'b0;
    #1;
    chk("rs2_unused_ctl_a", 16'(ctl_a), 16'(NORM));
    IDUsesRs2 = 1'b1;
    #1;
    chk("rs2_used_ctl_a", 16'(ctl_a), 16'(LD));
    EXRegWrite = 1'b0;
    #1;
    chk("rs2_nowrite_ctl_a", 16'(ctl_a), 16'(NORM));
    no_hazard;
    #1;

    // Three-bubble load-use on B
    hazard(16'd5);
    #1;
    chk("ls3_b0_ctl", 16'(ctl_b), 16'(LD));
    chk("ls3_b0_state", 16'(st_b), 16'd0);
    cyc;
    no_hazard;
    #1;
    chk("ls3_b1_ctl", 16'(ctl_b), 16'(LD));
    chk("ls3_b1_state", 16'(st_b), 16'd1);
    cyc;
    chk("ls3_b2_ctl", 16'(ctl_b), 16'(LD));
    chk("ls3_b2_state", 16'(st_b), 16'd1);
    cyc;
    chk("ls3_end_ctl", 16'(ctl_b), 16'(NORM));
    chk("ls3_end_state", 16'(st_b), 16'd0);
    chk("ls3_stall_b", sc_b, 16'd3);

    do_reset;

    // Branch together with load-use: branch wins
    hazard(16'd5);
    BranchTaken = 1'b1;
    #1;
    chk("br0_ctl_b", 16'(ctl_b), 16'(BR));
    chk("br0_ctl_a", 16'(ctl_a), 16'(BR));
    cyc;
    no_hazard;
    BranchTaken = 1'b0;
    #1;
    chk("br1_ctl_b", 16'(ctl_b), 16'(BR));
    chk("br1_state_b", 16'(st_b), 16'd2);
    chk("br1_ctl_a", 16'(ctl_a), 16'(NORM));
    cyc;
    chk("br_end_ctl_b", 16'(ctl_b), 16'(NORM));
    chk("br_flush_b", fc_b, 16'd1);
    chk("br_stall_b", sc_b, 16'd0);
    chk("br_flush_a", fc_a, 16'd1);
    chk("br_stall_a", sc_a, 16'd0);

    do_reset;

    // Freeze of 4 cycles inside a 3-bubble stall; watchdog at 4
    hazard(16'd5);
    #1;
    chk("fz_b0_ctl", 16'(ctl_b), 16'(LD));
    cyc;
    no_hazard;
    cyc;
    MemReq   = 1'b1;
    MemReady = 1'b0;
    #1;
    chk("fz_ctl_b", 16'(ctl_b), 16'(FRZ));
    chk("fz_ctl_a", 16'(ctl_a), 16'(FRZ));
    cyc;
    chk("fz1_err_b", 16'(err_b), 16'd0);
    cyc;
    cyc;
    chk("fz3_err_b", 16'(err_b), 16'd0);
    chk("fz3_state_b", 16'(st_b), 16'd1);
    chk("fz3_ctl_b", 16'(ctl_b), 16'(FRZ));
    cyc;
    chk("fz4_err_b", 16'(err_b), 16'd1);
    chk("fz4_err_a", 16'(err_a), 16'd0);
    MemReady = 1'b1;
    #1;
    chk("fz_resume_ctl_b", 16'(ctl_b), 16'(LD));
    chk("fz_resume_state_b", 16'(st_b), 16'd1);
    chk("fz_resume_stall_b", sc_b, 16'd2);
    cyc;
    chk("fz_end_ctl_b", 16'(ctl_b), 16'(NORM));
    chk("fz_end_state_b", 16'(st_b), 16'd0);
    chk("fz_end_stall_b", sc_b, 16'd3);
    MemReq = 1'b0;
    cyc;
    chk("fz_sticky_err_b", 16'(err_b), 16'd1);
    do_reset;
    chk("fz_rst_err_b", 16'(err_b), 16'd0);

    // StallCount saturation on A
    force dut_a.stall_cnt = 16'hFFFE;
    hazard(16'd9);
    cyc;
    release dut_a.stall_cnt;
    cyc;
    chk("sat2_stall_a", sc_a, 16'hFFFF);
    cyc;
    chk("sat3_stall_a", sc_a, 16'hFFFF);
    no_hazard;
    cyc;
    chk("sat_hold_stall_a", sc_a, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
